// File: rtl/sram_6116_arbiter.sv
// Round-robin arbiter sharing one single-port 2Kx8 (6116-class) RAM between a CPU port (A)
// and a video/scanner port (B); sequences the memory-IP strobes and returns read data with an ack.
module sram_6116_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_en,
  output logic              mem_we,
  output logic              busy
);

  localparam int unsigned       CNT_W    = 3;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  state_t           state;
  port_t            winner;
  port_t            last_gnt;
  logic [CNT_W-1:0] cnt;
  logic             a_wins_c;

  // On a tie the port that was not granted last wins.
  assign a_wins_c = a_req && (!b_req || (last_gnt == PORT_B));

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      winner      <= PORT_A;
      last_gnt    <= PORT_B;
      cnt         <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (a_req || b_req) begin
            if (a_wins_c) begin
              winner      <= PORT_A;
              last_gnt    <= PORT_A;
              mem_we      <= a_we;
              mem_addr    <= a_addr;
              mem_data_in <= a_wdata;
            end else begin
              winner      <= PORT_B;
              last_gnt    <= PORT_B;
              mem_we      <= b_we;
              mem_addr    <= b_addr;
              mem_data_in <= b_wdata;
            end
            mem_en <= 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_we still holds the latched direction during this cycle.
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            a_ack <= (winner == PORT_A);
            b_ack <= (winner == PORT_B);
            state <= ACK;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            if (winner == PORT_A) begin
              a_rdata <= mem_data_out;
            end else begin
              b_rdata <= mem_data_out;
            end
            a_ack <= (winner == PORT_A);
            b_ack <= (winner == PORT_B);
            state <= ACK;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_6116_arbiter.sv
// Self-checking bench: two arbiters (read latency 1 and 3), each on a behavioural RAM,
// checked against a shadow-memory / round-robin reference model.
module tb_sram_6116_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // [instance][port]; port 0 = A, port 1 = B
  logic        req   [2][2];
  logic        we    [2][2];
  logic [10:0] addr  [2][2];
  logic [7:0]  wdata [2][2];
  logic        ack   [2][2];
  logic [7:0]  rdata [2][2];
  logic [10:0] m_addr [2];
  logic [7:0]  m_din  [2];
  logic [7:0]  m_dout [2];
  logic        m_en   [2];
  logic        m_we   [2];
  logic        busy   [2];

  int checks = 0;
  int errors = 0;

  sram_6116_arbiter #(.ADDR_W(11), .DATA_W(8), .RD_LATENCY(1)) u0 (
    .clk(clk), .rst(rst),
    .a_req(req[0][0]), .a_we(we[0][0]), .a_addr(addr[0][0]), .a_wdata(wdata[0][0]),
    .a_ack(ack[0][0]), .a_rdata(rdata[0][0]),
    .b_req(req[0][1]), .b_we(we[0][1]), .b_addr(addr[0][1]), .b_wdata(wdata[0][1]),
    .b_ack(ack[0][1]), .b_rdata(rdata[0][1]),
    .mem_addr(m_addr[0]), .mem_data_in(m_din[0]), .mem_data_out(m_dout[0]),
    .mem_en(m_en[0]), .mem_we(m_we[0]), .busy(busy[0])
  );

  sram_6116_arbiter #(.ADDR_W(11), .DATA_W(8), .RD_LATENCY(3)) u1 (
    .clk(clk), .rst(rst),
    .a_req(req[1][0]), .a_we(we[1][0]), .a_addr(addr[1][0]), .a_wdata(wdata[1][0]),
    .a_ack(ack[1][0]), .a_rdata(rdata[1][0]),
    .b_req(req[1][1]), .b_we(we[1][1]), .b_addr(addr[1][1]), .b_wdata(wdata[1][1]),
    .b_ack(ack[1][1]), .b_rdata(rdata[1][1]),
    .mem_addr(m_addr[1]), .mem_data_in(m_din[1]), .mem_data_out(m_dout[1]),
    .mem_en(m_en[1]), .mem_we(m_we[1]), .busy(busy[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] dflt(input int i, input int a);
    return 8'(a ^ (a >> 3) ^ (i * 90) ^ 8'h81);
  endfunction

  // Behavioural RAM: preloaded while rst is high, read data valid exactly lat() cycles after en.
  logic [7:0] mem  [2][2048];
  logic [7:0] pipe [2][3];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int a = 0; a < 2048; a++) mem[i][a] <= dflt(i, a);
      end else if (m_en[i] && m_we[i]) begin
        mem[i][m_addr[i]] <= m_din[i];
      end
      pipe[i][0] <= (m_en[i] && !m_we[i]) ? mem[i][m_addr[i]] : 8'h00;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign m_dout[0] = pipe[0][0];
  assign m_dout[1] = pipe[1][2];

  // Reference model state
  logic [7:0] shadow   [2][2048];
  int         last_gnt [2];
  logic [7:0] exp_rd   [2][2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 2048; a++) shadow[i][a] = dflt(i, a);
      last_gnt[i]  = 1;
      exp_rd[i][0] = 8'h00;
      exp_rd[i][1] = 8'h00;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
      end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One access from a single port; checks strobes, latency, rdata and the other port's ack.
  task automatic access(input int i, input int p, input logic w, input logic [10:0] a,
                        input logic [7:0] d);
    int  exp_cyc;
    int  en_cnt;
    bit  got;
    bit  other;
    logic [7:0] want;
    @(negedge clk);
    chk("idle_before_req", 32'(busy[i]), 32'd0);
    req[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wdata[i][p] = d;
    last_gnt[i] = p;
    exp_cyc = w ? 2 : 2 + lat(i);
    want = w ? exp_rd[i][p] : shadow[i][a];
    en_cnt = 0; got = 0; other = 0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (m_en[i]) en_cnt++;
      if (ack[i][1-p]) other = 1;
      if (k == 1) begin
        chk("issue_en", 32'(m_en[i]), 32'd1);
        chk("issue_we", 32'(m_we[i]), 32'(w));
        chk("issue_addr", 32'(m_addr[i]), 32'(a));
        chk("issue_din", 32'(m_din[i]), 32'(d));
        chk("issue_busy", 32'(busy[i]), 32'd1);
      end
      if (ack[i][p]) begin
        got = 1;
        req[i][p] = 1'b0;
        chk("ack_cycle", 32'(k), 32'(exp_cyc));
        chk("ack_rdata", 32'(rdata[i][p]), 32'(want));
        chk("en_pulses", 32'(en_cnt), 32'd1);
        chk("other_ack", 32'(other), 32'd0);
      end
    end
    if (!got) begin
      req[i][p] = 1'b0;
      chk("ack_timeout", 32'd0, 32'd1);
    end
    if (w) shadow[i][a] = d;
    else   exp_rd[i][p] = want;
  endtask

  initial begin
    int exp_port;
    int gp;
    int en_cnt;
    int ack_cnt;
    bit got;

    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_en", 32'(m_en[i]), 32'd0);
      chk("rst_we", 32'(m_we[i]), 32'd0);
      chk("rst_addr", 32'(m_addr[i]), 32'd0);
      chk("rst_acks", {30'd0, ack[i][1], ack[i][0]}, 32'd0);
      chk("rst_rdata", {16'd0, rdata[i][1], rdata[i][0]}, 32'd0);
    end
    rst = 1'b0;

    // Basic write then read on port A, latency 1
    access(0, 0, 1'b1, 11'h123, 8'hA5);
    access(0, 0, 1'b0, 11'h123, 8'h00);
    chk("a_rdata_a5", 32'(rdata[0][0]), 32'hA5);

    // Both ports requesting continuously: grants alternate, one idle cycle after each ack
    @(negedge clk);
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 11'h010; wdata[0][0] = 8'h11;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 11'h020; wdata[0][1] = 8'h22;
    for (int n = 0; n < 8; n++) begin
      exp_port = (last_gnt[0] == 0) ? 1 : 0;
      en_cnt = 0; got = 0; gp = -1;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (m_en[0]) en_cnt++;
        if (ack[0][0] || ack[0][1]) begin
          got = 1;
          gp = (ack[0][0] && ack[0][1]) ? 2 : (ack[0][0] ? 0 : 1);
        end
      end
      if (n == 7) begin req[0][0] = 1'b0; req[0][1] = 1'b0; end
      chk("rr_order", 32'(gp), 32'(exp_port));
      chk("rr_en_pulses", 32'(en_cnt), 32'd1);
      last_gnt[0] = exp_port;
      shadow[0][(exp_port == 0) ? 11'h010 : 11'h020] = (exp_port == 0) ? 8'h11 : 8'h22;
      @(negedge clk);
      chk("rr_idle_gap", {30'd0, busy[0], m_en[0]}, 32'd0);
    end
    access(0, 1, 1'b0, 11'h020, 8'h00);

    // Latency-3 instance: B write, read, then a write that must not disturb b_rdata
    access(1, 1, 1'b1, 11'h7FF, 8'h3C);
    access(1, 1, 1'b0, 11'h7FF, 8'h00);
    access(1, 1, 1'b1, 11'h7FF, 8'h99);
    chk("b_rdata_held", 32'(rdata[1][1]), 32'h3C);

    // Reset in the WAIT cycle of an A read
    @(negedge clk);
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 11'h123;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wait_busy", 32'(busy[0]), 32'd0);
    chk("rst_wait_ack", 32'(ack[0][0]), 32'd0);
    chk("rst_wait_en", {30'd0, m_en[0], m_we[0]}, 32'd0);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset in the ISSUE cycle of a write: mem_we drops without a clock edge
    @(negedge clk);
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 11'h044; wdata[0][1] = 8'h5E;
    @(negedge clk);
    chk("pre_rst_we", 32'(m_we[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_issue_we", {30'd0, m_en[0], m_we[0]}, 32'd0);
    chk("rst_issue_busy", 32'(busy[0]), 32'd0);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    access(0, 0, 1'b0, 11'h123, 8'h00);

    // Request dropped and address changed during ISSUE: original access completes once
    access(0, 0, 1'b1, 11'h055, 8'h77);
    @(negedge clk);
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 11'h055;
    @(negedge clk);
    chk("drop_issue_addr", 32'(m_addr[0]), 32'h055);
    req[0][0] = 1'b0; addr[0][0] = 11'h0AA; we[0][0] = 1'b1;
    en_cnt = 0; ack_cnt = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (m_en[0]) en_cnt++;
      if (ack[0][0]) begin
        ack_cnt++;
        chk("drop_ack_cycle", 32'(k), 32'd3);
        chk("drop_rdata", 32'(rdata[0][0]), 32'h77);
      end
    end
    chk("drop_ack_count", 32'(ack_cnt), 32'd1);
    chk("drop_no_reissue", 32'(en_cnt), 32'd0);
    last_gnt[0] = 0;
    exp_rd[0][0] = 8'h77;

    // Randomized single-port traffic on both instances
    for (int n = 0; n < 60; n++) begin
      int i;
      int p;
      i = int'($urandom_range(1, 0));
      p = int'($urandom_range(1, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      access(i, p, 1'($urandom_range(1, 0)), 11'($urandom_range(15, 0) + (p * 1024)),
             8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
